uart_char_buffer: RTL and testbench
===================================

Name: uart_char_buffer

Overview:
- Parametrised receive-side character buffer between rcv_block and a bank of alpha_display instances.
- Captures bytes from rcv_block with a fully synchronous data_ready/data_read handshake; no clocking on data_ready.
- Keeps the last NUM_CHARS characters, newest at position 0, and acts on backspace and clear control codes.
- Provides a hold input that back-pressures the receiver and freezes the display.

Parameters:
- NUM_CHARS, 8: number of character slots; legal range ≥ 2.
- DATA_W, 8: bits per character.
- BLANK, 8'h00: value placed in emptied or reset slots.
- CTRL_EN, 1: 1 = decode control codes; 0 = every byte is stored as a character.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_W  byte from rcv_block.
- data_ready  in  1  rcv_block has a byte pending; level, held until acknowledged.
- hold  in  1  1 = accept nothing and leave the display frozen.
- data_read  out  1  registered one-cycle acknowledge to rcv_block.
- disp_data  out  NUM_CHARS*DATA_W  packed slots; slot i occupies bits [i*DATA_W +: DATA_W]; slot 0 is newest.
- char_count  out  $clog2(NUM_CHARS+1)  number of valid characters held.
- full  out  1  char_count == NUM_CHARS.

Behaviour:
- Reset (async assert, sync release to first clk edge):
  - all slots = BLANK, char_count = 0, full = 0, data_read = 0, state = IDLE.
  - Reset mid-handshake discards the pending byte's effect and drops data_read immediately.
- FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: at an edge with data_ready=1 and hold=0, process rx_data, register data_read=1, go to ACK.
  - IDLE with hold=1: no capture and no ack, whatever data_ready is. The hold-wins rule also covers hold and data_ready rising in the same cycle.
  - ACK: data_read=1 for exactly this one cycle; next state WAIT_LOW.
  - WAIT_LOW: data_read=0; go to IDLE once data_ready samples 0.
  - No byte is processed twice, even if rcv_block keeps data_ready high for several cycles after the ack.
- Latency: disp_data, char_count and data_read all update on the same edge at which data_ready is sampled high in IDLE.
- Throughput: at most one byte per 3 cycles.
- Byte processing when CTRL_EN=1:
  - 8'h08 (backspace): slot[i] <= slot[i+1] for i < NUM_CHARS-1; top slot <= BLANK; char_count decrements. At char_count=0, no change, but the byte is still acknowledged.
  - 8'h0C (clear): all slots = BLANK; char_count = 0; acknowledged.
  - 8'h0D and 8'h0A: ignored, but acknowledged.
  - Any other value is stored as a character.
- Storing a character (also every byte when CTRL_EN=0):
  - slot[i] <= slot[i-1] for i ≥ 1; slot[0] <= rx_data.
  - The oldest character is discarded when the buffer is full.
  - char_count increments and saturates at NUM_CHARS.
- full is derived combinationally from the registered char_count.
- No arithmetic wraps; char_count never underflows or exceeds NUM_CHARS.
- rx_data is sampled only on the capture edge; values at other times are don't-care.

Decomposition:
- Package uart_char_pkg:
  - state enum (IDLE, ACK, WAIT_LOW);
  - constants CH_BS = 8'h08, CH_FF = 8'h0C, CH_CR = 8'h0D, CH_LF = 8'h0A.
- Optional sub-module char_shift_reg: the bidirectional NUM_CHARS×DATA_W shift register, with a shift-in-at-0, a shift-toward-0-with-BLANK-fill and a clear command.
- The FSM and control decode stay in uart_char_buffer.

Test Plan (NUM_CHARS=8, BLANK=0, CTRL_EN=1):
- Reset, then send "A","B","C" (each data_ready held high 4 cycles) -> one data_read pulse per byte; slots 0..2 = 43,42,41; char_count=3; full=0.
- Send 9 chars 0x31..0x39 -> slot0=0x39 … slot7=0x32; 0x31 dropped; char_count=8; full=1.
- From "ABC", send 0x08 twice -> slot0=41, slots1..7=00, char_count=1. Then 0x08 twice more -> count 0; the extra backspace is acked with no change.
- Buffer full, send 0x0C -> all slots 00, char_count=0, full=0. Send 0x0D -> acked, no state change.
- hold=1 with data_ready=1 and rx_data=0x5A for 20 cycles -> data_read stays 0 and the display is unchanged. Drop hold -> ack within 1 cycle and slot0=5A.
- Assert rst in the ACK cycle -> data_read=0 and all slots 00 immediately (async); after release, FSM in IDLE and the next byte is accepted normally.

Source files
------------

// File: rtl/uart_char_pkg.sv
// Shared types and control-code constants for the UART character buffer.
package uart_char_pkg;

  // Receive handshake states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  // Control codes recognised when control decoding is enabled.
  localparam logic [7:0] CH_BS = 8'h08;  // backspace: drop newest character
  localparam logic [7:0] CH_FF = 8'h0C;  // form feed: clear the display
  localparam logic [7:0] CH_CR = 8'h0D;  // carriage return: ignored
  localparam logic [7:0] CH_LF = 8'h0A;  // line feed: ignored

endpackage : uart_char_pkg

// File: rtl/char_shift_reg.sv
// Bidirectional NUM_CHARS x DATA_W character shift register.
// push  : shift toward the oldest end, new character enters slot 0.
// pop   : shift toward slot 0, the top slot is filled with BLANK.
// clear : every slot becomes BLANK.
module char_shift_reg #(
  parameter int              NUM_CHARS = 8,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] BLANK   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [DATA_W-1:0]           din,
  output logic [NUM_CHARS*DATA_W-1:0] slots_flat
);

  logic [DATA_W-1:0] slots [NUM_CHARS];

  // Slot storage: clear has priority, then push, then pop.
  // NOTE: the slots are plain flops, not a RAM, so they can and must take the
  // BLANK reset value; a RAM-mapped array would be left unreset instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) slots[i] <= BLANK;
    end else if (clear) begin
      for (int i = 0; i < NUM_CHARS; i++) slots[i] <= BLANK;
    end else if (push) begin
      // NOTE: non-blocking assignments make every slot read its neighbour's
      // old value, so the whole array moves one place in a single edge.
      slots[0] <= din;
      for (int i = 1; i < NUM_CHARS; i++) slots[i] <= slots[i-1];
    end else if (pop) begin
      for (int i = 0; i < NUM_CHARS - 1; i++) slots[i] <= slots[i+1];
      slots[NUM_CHARS-1] <= BLANK;
    end
  end

  // Flatten the slots; slot i sits at bits [i*DATA_W +: DATA_W].
  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_flat
    assign slots_flat[g*DATA_W +: DATA_W] = slots[g];
  end

endmodule : char_shift_reg

// File: rtl/uart_char_buffer.sv
// Receive-side character buffer between rcv_block and the alpha displays.
// Captures one byte per data_ready/data_read handshake, keeps the newest
// NUM_CHARS characters (newest in slot 0) and acts on backspace / clear.
module uart_char_buffer
  import uart_char_pkg::*;
#(
  parameter int                NUM_CHARS = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] BLANK     = 8'h00,
  parameter bit                CTRL_EN   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              rx_data,
  input  logic                           data_ready,
  input  logic                           hold,
  output logic                           data_read,
  output logic [NUM_CHARS*DATA_W-1:0]    disp_data,
  output logic [$clog2(NUM_CHARS+1)-1:0] char_count,
  output logic                           full
);

  localparam int                CNT_W     = $clog2(NUM_CHARS + 1);
  localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(NUM_CHARS);
  localparam logic [DATA_W-1:0] C_BS      = DATA_W'(CH_BS);
  localparam logic [DATA_W-1:0] C_FF      = DATA_W'(CH_FF);
  localparam logic [DATA_W-1:0] C_CR      = DATA_W'(CH_CR);
  localparam logic [DATA_W-1:0] C_LF      = DATA_W'(CH_LF);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             data_read_q;
  logic             capture;
  logic             sr_push, sr_pop, sr_clear;

  // A byte is taken only in IDLE; hold overrides data_ready, even when both
  // rise together, so the receiver is stalled and the display stays frozen.
  assign capture = (state_q == IDLE) && data_ready && !hold;

  // Next-state and byte-decode logic.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sr_push  = 1'b0;
    sr_pop   = 1'b0;
    sr_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = ACK;
          if (CTRL_EN && rx_data == C_BS) begin
            // Backspace on an empty buffer is acknowledged but changes nothing.
            if (count_q != '0) begin
              sr_pop  = 1'b1;
              count_d = count_q - CNT_W'(1);
            end
          end else if (CTRL_EN && rx_data == C_FF) begin
            sr_clear = 1'b1;
            count_d  = '0;
          end else if (CTRL_EN && (rx_data == C_CR || rx_data == C_LF)) begin
            // Acknowledged, otherwise ignored.
          end else begin
            // Oldest character falls off the end when already full.
            sr_push = 1'b1;
            if (count_q != MAX_COUNT) count_d = count_q + CNT_W'(1);
          end
        end
      end
      ACK:      state_d = WAIT_LOW;
      // Waiting for data_ready to drop keeps one byte from being taken twice.
      WAIT_LOW: if (!data_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, count and acknowledge registers; data_read is high exactly in ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      data_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      data_read_q <= capture;
    end
  end

  char_shift_reg #(
    .NUM_CHARS (NUM_CHARS),
    .DATA_W    (DATA_W),
    .BLANK     (BLANK)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .push       (sr_push),
    .pop        (sr_pop),
    .clear      (sr_clear),
    .din        (rx_data),
    .slots_flat (disp_data)
  );

  assign data_read  = data_read_q;
  assign char_count = count_q;
  assign full       = (count_q == MAX_COUNT);

endmodule : uart_char_buffer

// File: tb/tb_uart_char_buffer.sv
// Directed self-checking bench for uart_char_buffer (NUM_CHARS=8, BLANK=0).
module tb_uart_char_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        data_ready = 1'b0;
  logic        hold = 1'b0;
  logic        data_read;
  logic [63:0] disp_data;
  logic [3:0]  char_count;
  logic        full;

  int checks = 0;
  int errors = 0;

  uart_char_buffer #(
    .NUM_CHARS (8),
    .DATA_W    (8),
    .BLANK     (8'h00),
    .CTRL_EN   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .data_ready (data_ready),
    .hold       (hold),
    .data_read  (data_read),
    .disp_data  (disp_data),
    .char_count (char_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a byte with data_ready held for 4 cycles; exactly one ack expected.
  task automatic send_byte(input logic [7:0] b);
    int acks;
    acks       = 0;
    rx_data    = b;
    data_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (data_read) acks++;
    end
    data_ready = 1'b0;
    rx_data    = 8'hxx;
    @(negedge clk);
    if (data_read) acks++;
    @(negedge clk);
    check($sformatf("ack_count_%h", b), 64'(acks), 64'd1);
  endtask

  initial begin
    int acks;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_disp",  disp_data,  64'h0);
    check("reset_count", 64'(char_count), 64'd0);
    check("reset_full",  64'(full),  64'd0);
    check("reset_ack",   64'(data_read), 64'd0);

    // "ABC": slot0=C, slot1=B, slot2=A.
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    check("abc_disp",  disp_data, 64'h0000_0000_0041_4243);
    check("abc_count", 64'(char_count), 64'd3);
    check("abc_full",  64'(full), 64'd0);

    // Two backspaces leave only "A".
    send_byte(8'h08); send_byte(8'h08);
    check("bs2_disp",  disp_data, 64'h0000_0000_0000_0041);
    check("bs2_count", 64'(char_count), 64'd1);
    // Two more: the second hits an empty buffer and is just acknowledged.
    send_byte(8'h08); send_byte(8'h08);
    check("bs4_disp",  disp_data, 64'h0);
    check("bs4_count", 64'(char_count), 64'd0);

    // Nine characters into eight slots: 0x31 is discarded.
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
    check("nine_disp",  disp_data, 64'h3233_3435_3637_3839);
    check("nine_count", 64'(char_count), 64'd8);
    check("nine_full",  64'(full), 64'd1);

    // Clear from full.
    send_byte(8'h0C);
    check("ff_disp",  disp_data, 64'h0);
    check("ff_count", 64'(char_count), 64'd0);
    check("ff_full",  64'(full), 64'd0);

    // CR and LF are acknowledged but change nothing.
    send_byte(8'h41);
    send_byte(8'h0D);
    send_byte(8'h0A);
    check("crlf_disp",  disp_data, 64'h41);
    check("crlf_count", 64'(char_count), 64'd1);

    // hold and data_ready rise together: nothing taken for 20 cycles.
    acks       = 0;
    hold       = 1'b1;
    rx_data    = 8'h5A;
    data_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (data_read) acks++;
    end
    check("hold_acks",  64'(acks), 64'd0);
    check("hold_disp",  disp_data, 64'h41);
    check("hold_count", 64'(char_count), 64'd1);
    hold = 1'b0;
    @(negedge clk);
    check("unhold_ack",   64'(data_read), 64'd1);
    check("unhold_disp",  disp_data, 64'h415A);
    check("unhold_count", 64'(char_count), 64'd2);
    data_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted during the ACK cycle acts immediately.
    rx_data    = 8'h55;
    data_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_ack", 64'(data_read), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_ack",   64'(data_read), 64'd0);
    check("rst_disp",  disp_data, 64'h0);
    check("rst_count", 64'(char_count), 64'd0);
    data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h61);
    check("post_rst_disp",  disp_data, 64'h61);
    check("post_rst_count", 64'(char_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_uart_char_buffer
